// File: rtl/comparador_sar_ctrl_if.sv
// comparador_sar_ctrl_if
//   Groups the signals between the SAR search controller and its environment
//   (the magnitude comparator plus whoever launches searches).
//   Signals:
//     start       request a new search (environment -> controller)
//     cmp_result  comparator result {in1>in2, in1==in2, in1<in2}
//     guess       value the controller drives onto comparator input2
//     busy        search in progress
//     done        search finished; found_value is valid
//     fault       comparator answered inconsistently or with an illegal code
//     found_value located target value
//     probes      number of comparator evaluations in the current search
//
//   Handshake: start is a level request sampled on the rising clock edge. It
//   is accepted on any edge where busy=0 (which also covers done=1 and
//   fault=1) and ignored on every edge where busy=1. There is no ready signal;
//   busy is the "not ready" indication. cmp_result must be valid whenever the
//   controller evaluates, i.e. it is a combinational function of guess.
//   Modports: master = controller side, slave = environment side.
interface comparador_sar_ctrl_if #(
    parameter int WIDTH = 4
);
    localparam int PW = $clog2(WIDTH + 2);

    logic             start;
    logic [2:0]       cmp_result;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             fault;
    logic [WIDTH-1:0] found_value;
    logic [PW-1:0]    probes;

    modport master (
        input  start, cmp_result,
        output guess, busy, done, fault, found_value, probes
    );

    modport slave (
        output start, cmp_result,
        input  guess, busy, done, fault, found_value, probes
    );
endinterface

// File: rtl/comparador_sar_ctrl.sv
// comparador_sar_ctrl
//   Binary-search (SAR) controller wrapped around a WIDTH-bit magnitude
//   comparator. The comparator's input1 holds an unknown target; this block
//   drives input2 with successive guesses, waits SETTLE_CYCLES edges after each
//   guess change, samples the comparator result, and narrows [lo, hi] until the
//   comparator reports equality.
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous, active-high reset
//     bus      comparador_sar_ctrl_if.master (start, cmp_result in; guess, busy,
//              done, fault, found_value, probes out)
//     state_o  current FSM state (debug visibility)
module comparador_sar_ctrl #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    comparador_sar_ctrl_if.master       bus,
    output logic [2:0]                  state_o
);
    localparam int PW = $clog2(WIDTH + 2);
    // lo/hi need two extra bits so guess-1 at 0 and guess+1 at max do not wrap.
    localparam int AW = WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_EVAL   = 3'd2,
        S_DONE   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    // With no settle time a new guess is evaluated on the very next edge.
    localparam state_t S_PROBE = (SETTLE_CYCLES == 0) ? S_EVAL : S_SETTLE;
    localparam logic [2:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 3'd0 : 3'(SETTLE_CYCLES - 1);

    localparam logic signed [AW-1:0] ONE    = AW'(1);
    localparam logic signed [AW-1:0] HI_MAX = {2'b00, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0]     MID0   = {1'b0, {(WIDTH-1){1'b1}}};

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       guess_q, guess_d;
    logic signed [AW-1:0]   lo_q, lo_d;
    logic signed [AW-1:0]   hi_q, hi_d;
    logic [2:0]             settle_q, settle_d;
    logic [PW-1:0]          probes_q, probes_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   fault_q, fault_d;
    logic [WIDTH-1:0]       found_q, found_d;

    // Scratch values for the EVAL update.
    logic signed [AW-1:0]   guess_ext;
    logic signed [AW-1:0]   lo_n, hi_n, sum_n;
    logic                   upd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            guess_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            settle_q <= '0;
            probes_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            found_q  <= '0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            settle_q <= settle_d;
            probes_q <= probes_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            found_q  <= found_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        guess_d   = guess_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        settle_d  = settle_q;
        probes_d  = probes_q;
        busy_d    = busy_q;
        done_d    = done_q;
        fault_d   = fault_q;
        found_d   = found_q;
        guess_ext = {2'b00, guess_q};
        lo_n      = lo_q;
        hi_n      = hi_q;
        sum_n     = '0;
        upd       = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (bus.start) begin
                    lo_d     = '0;
                    hi_d     = HI_MAX;
                    guess_d  = MID0;
                    probes_d = '0;
                    settle_d = '0;
                    done_d   = 1'b0;
                    fault_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_PROBE;
                end
            end

            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_EVAL;
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end

            S_EVAL: begin
                probes_d = probes_q + PW'(1);
                case (bus.cmp_result)
                    3'b010: begin
                        found_d = guess_q;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                    3'b100: begin
                        lo_n = guess_ext + ONE;
                        upd  = 1'b1;
                    end
                    3'b001: begin
                        hi_n = guess_ext - ONE;
                        upd  = 1'b1;
                    end
                    default: begin
                        // Zero or multi-hot result: the comparator is broken.
                        fault_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FAULT;
                    end
                endcase

                if (upd) begin
                    lo_d = lo_n;
                    hi_d = hi_n;
                    if (lo_n > hi_n) begin
                        // Window collapsed: answers contradict each other.
                        fault_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FAULT;
                    end else begin
                        // lo_n..hi_n are both in 0..2^WIDTH-1 here, so the
                        // sum is non-negative and bits [WIDTH:1] are sum>>1.
                        sum_n    = lo_n + hi_n;
                        guess_d  = sum_n[WIDTH:1];
                        settle_d = '0;
                        state_d  = S_PROBE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.guess       = guess_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.fault       = fault_q;
    assign bus.found_value = found_q;
    assign bus.probes      = probes_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_comparador_sar_ctrl.sv
module tb_comparador_sar_ctrl;
  logic clk;
  logic rst;
  logic start;
  logic sel;
  logic [3:0] target;
  logic force_en;
  logic [2:0] force_val;
  logic [2:0] st_a, st_b;

  int n_vec = 0;
  int n_err = 0;

  comparador_sar_ctrl_if #(.WIDTH(4)) ifa ();
  comparador_sar_ctrl_if #(.WIDTH(4)) ifb ();

  // Instance a: default settle time. Instance b: zero settle time.
  comparador_sar_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.master), .state_o(st_a)
  );
  comparador_sar_ctrl #(.WIDTH(4), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.master), .state_o(st_b)
  );

  // Magnitude comparator: {in1>in2, in1==in2, in1<in2}, in1 = target.
  function automatic logic [2:0] cmp4(input logic [3:0] in1, input logic [3:0] in2);
    return {in1 > in2, in1 == in2, in1 < in2};
  endfunction

  assign ifa.cmp_result = force_en ? force_val : cmp4(target, ifa.guess);
  assign ifb.cmp_result = force_en ? force_val : cmp4(target, ifb.guess);
  assign ifa.start = start & ~sel;
  assign ifb.start = start & sel;

  logic [3:0] o_guess, o_found;
  logic [2:0] o_probes;
  logic o_busy, o_done, o_fault;
  assign o_guess  = sel ? ifb.guess       : ifa.guess;
  assign o_found  = sel ? ifb.found_value : ifa.found_value;
  assign o_probes = sel ? ifb.probes      : ifa.probes;
  assign o_busy   = sel ? ifb.busy        : ifa.busy;
  assign o_done   = sel ? ifb.done        : ifa.done;
  assign o_fault  = sel ? ifb.fault       : ifa.fault;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_idle_zero(input string name);
    if (o_guess !== 4'd0) begin n_err++; $display("FAIL %s guess got %0d want 0", name, o_guess); end
    n_vec++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL %s busy got %b want 0", name, o_busy); end
    n_vec++;
    if (o_done !== 1'b0) begin n_err++; $display("FAIL %s done got %b want 0", name, o_done); end
    n_vec++;
    if (o_fault !== 1'b0) begin n_err++; $display("FAIL %s fault got %b want 0", name, o_fault); end
    n_vec++;
    if (o_found !== 4'd0) begin n_err++; $display("FAIL %s found got %0d want 0", name, o_found); end
    n_vec++;
    if (o_probes !== 3'd0) begin n_err++; $display("FAIL %s probes got %0d want 0", name, o_probes); end
    n_vec++;
  endtask

  // Reference search: plain binary search over 0..15 driven by the comparator
  // answers (true comparator or a forced constant code), then a cycle-by-cycle
  // check of the selected instance. Entered and left on a falling edge.
  task automatic run_check(input string name, input int tgt, input bit s,
                           input bit use_force, input logic [2:0] fc, input bit glitch);
    logic [3:0] exp_q[$];
    logic [2:0] code;
    int lo, hi, g, np, per, last, gl, k;
    bit is_fault, fin;
    logic [3:0] e_guess;
    logic [2:0] e_probes;
    logic e_busy, e_done, e_fault;

    lo = 0; hi = 15; is_fault = 0; fin = 0;
    while (!fin) begin
      g = (lo + hi) / 2;
      exp_q.push_back(4'(g));
      if (use_force) code = fc;
      else if (tgt > g) code = 3'b100;
      else if (tgt == g) code = 3'b010;
      else code = 3'b001;
      if (code == 3'b010) fin = 1;
      else if (code == 3'b100 || code == 3'b001) begin
        if (code == 3'b100) lo = g + 1; else hi = g - 1;
        if (lo > hi) begin is_fault = 1; fin = 1; end
      end else begin
        is_fault = 1; fin = 1;
      end
    end
    np = exp_q.size();
    per = s ? 1 : 2;
    last = np * per;
    gl = glitch ? int'($urandom_range(0, last - 1)) : -1;

    target = 4'(tgt); sel = s; force_en = use_force; force_val = fc;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= last; j++) begin
      if (j > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      k = j / per;
      if (j < last) begin
        e_guess = exp_q[k]; e_probes = 3'(k); e_busy = 1; e_done = 0; e_fault = 0;
      end else begin
        e_guess = exp_q[np-1]; e_probes = 3'(np); e_busy = 0; e_done = !is_fault; e_fault = is_fault;
      end
      if (o_guess !== e_guess) begin n_err++; $display("FAIL %s guess j=%0d got %0d want %0d", name, j, o_guess, e_guess); end
      n_vec++;
      if (o_probes !== e_probes) begin n_err++; $display("FAIL %s probes j=%0d got %0d want %0d", name, j, o_probes, e_probes); end
      n_vec++;
      if (o_busy !== e_busy) begin n_err++; $display("FAIL %s busy j=%0d got %b want %b", name, j, o_busy, e_busy); end
      n_vec++;
      if (o_done !== e_done) begin n_err++; $display("FAIL %s done j=%0d got %b want %b", name, j, o_done, e_done); end
      n_vec++;
      if (o_fault !== e_fault) begin n_err++; $display("FAIL %s fault j=%0d got %b want %b", name, j, o_fault, e_fault); end
      n_vec++;
      if (j == last && e_done) begin
        if (o_found !== 4'(tgt)) begin n_err++; $display("FAIL %s found got %0d want %0d", name, o_found, tgt); end
        n_vec++;
      end
      start = (j == gl);
    end
    start = 1'b0;
    force_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sel = 1'b0; target = 4'd0;
    force_en = 1'b0; force_val = 3'b000;
    #12;
    check_idle_zero("reset_a");
    sel = 1'b1;
    #1;
    check_idle_zero("reset_b");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known;
    run_check("t5", 5, 0, 0, 3'b000, 0);
    run_check("t15", 15, 0, 0, 3'b000, 0);
    run_check("t0", 0, 0, 0, 3'b000, 0);
    run_check("t10", 10, 0, 0, 3'b000, 0);
    run_check("restart_t2", 2, 0, 0, 3'b000, 0);
  endtask

  task automatic test_fault;
    run_check("fault_000", 9, 0, 1, 3'b000, 0);
    run_check("fault_110", 9, 0, 1, 3'b110, 0);
    run_check("fault_lo_gt_hi", 9, 0, 1, 3'b001, 0);
    run_check("fault_clear", 12, 0, 0, 3'b000, 0);
  endtask

  task automatic test_back_to_back;
    run_check("glitch_t10", 10, 0, 0, 3'b000, 1);
    run_check("b2b_t7", 7, 0, 0, 3'b000, 0);
    run_check("b2b_t8", 8, 0, 0, 3'b000, 1);
  endtask

  task automatic test_settle0;
    run_check("s0_t5", 5, 1, 0, 3'b000, 0);
    run_check("s0_t15", 15, 1, 0, 3'b000, 0);
    run_check("s0_fault", 3, 1, 1, 3'b001, 0);
  endtask

  task automatic test_random;
    bit s;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      run_check("rand", int'($urandom_range(0, 15)), s, 0, 3'b000, !s && ($urandom_range(0, 1) == 1));
    end
  endtask

  task automatic test_reset_mid;
    target = 4'd10; sel = 1'b0; force_en = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL reset_mid pre busy got %b want 1", o_busy); end
    n_vec++;
    rst = 1'b1;
    #1;
    check_idle_zero("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("after_reset_mid");
  endtask

  initial begin
    test_reset;
    test_known;
    test_fault;
    test_back_to_back;
    test_settle0;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
